// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: PC, instruction-memory and decode-side signals of the fetch stage.
// master is the fetch unit; slave is the surrounding PC/memory/decode environment.
interface instruction_fetch_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           pc_in;
   logic                  pc_valid;
   logic                  pc_advance;
   logic                  redirect;
   logic                  mem_req;
   logic [31:0]           mem_addr;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_err;
   logic [DATA_WIDTH-1:0] instr_out;
   logic [31:0]           instr_pc;
   logic                  instr_valid;
   logic                  decode_ready;
   logic                  fetch_fault;
   modport master (
      input  pc_in, pc_valid, redirect, mem_ack, mem_rdata, mem_err, decode_ready,
      output pc_advance, mem_req, mem_addr, instr_out, instr_pc, instr_valid, fetch_fault
   );
   modport slave (
      output pc_in, pc_valid, redirect, mem_ack, mem_rdata, mem_err, decode_ready,
      input  pc_advance, mem_req, mem_addr, instr_out, instr_pc, instr_valid, fetch_fault
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches one word per PC over req/ack and holds it for decode.
// Misaligned PCs, bus errors and timeouts deliver a NOP fault word, then the unit halts.
module instruction_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MAX_WAIT   = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   instruction_fetch_unit_if.master bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_e;
   state_e                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] instr_out_q, instr_out_d;
   logic [31:0]           instr_pc_q, instr_pc_d;
   logic                  instr_valid_q, instr_valid_d;
   logic                  fetch_fault_q, fetch_fault_d;
   logic                  pc_advance_q, pc_advance_d;
   logic                  drop_q, drop_d;
   logic [WW-1:0]         wait_q, wait_d;
   logic                  dropped, timeout, fault;
   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_fault_d = fetch_fault_q;
      pc_advance_d  = 1'b0;
      drop_d        = drop_q;
      wait_d        = wait_q;
      dropped       = drop_q | bus.redirect;
      timeout       = wait_q == WW'(MAX_WAIT - 1);
      fault         = !bus.mem_ack || bus.mem_err;
      case (state_q)
         // pc_advance_q still high means pc_in has not stepped yet
         IDLE: if (bus.pc_valid && !bus.redirect && !pc_advance_q) begin
            if (bus.pc_in[1:0] == 2'b00) begin
               mem_req_d  = 1'b1;
               mem_addr_d = bus.pc_in;
               state_d    = REQ;
            end else begin
               instr_out_d   = NOP_INSTR;
               instr_pc_d    = bus.pc_in;
               fetch_fault_d = 1'b1;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         REQ: if (bus.mem_ack || timeout) begin
            mem_req_d     = 1'b0;
            wait_d        = '0;
            drop_d        = 1'b0;
            instr_out_d   = dropped ? instr_out_q : (fault ? NOP_INSTR : bus.mem_rdata);
            instr_pc_d    = dropped ? instr_pc_q : mem_addr_q;
            fetch_fault_d = !dropped && fault;
            instr_valid_d = !dropped;
            state_d       = dropped ? IDLE : HOLD;
         end else begin
            wait_d = wait_q + WW'(1);
            drop_d = dropped;
         end
         HOLD: if (bus.redirect) begin
            instr_valid_d = 1'b0;
            fetch_fault_d = 1'b0;
            state_d       = IDLE;
         end else if (bus.decode_ready) begin
            instr_valid_d = 1'b0;
            pc_advance_d  = !fetch_fault_q;
            state_d       = fetch_fault_q ? HALT : IDLE;
         end
         HALT: if (bus.redirect) begin
            fetch_fault_d = 1'b0;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_out_q   <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         pc_advance_q  <= 1'b0;
         drop_q        <= 1'b0;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_out_q   <= instr_out_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_fault_q <= fetch_fault_d;
         pc_advance_q  <= pc_advance_d;
         drop_q        <= drop_d;
         wait_q        <= wait_d;
      end
   end
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_out   = instr_out_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.fetch_fault = fetch_fault_q;
   // a same-cycle redirect replaces the PC, so the step must not happen
   assign bus.pc_advance  = pc_advance_q & ~bus.redirect;
   a_addr_stable: assert property (@(posedge CLK) disable iff (!RESET)
      mem_req_q |=> !mem_req_q || $stable(mem_addr_q));
   a_wait_bound: assert property (@(posedge CLK) disable iff (!RESET)
      state_q == REQ |-> wait_q < WW'(MAX_WAIT));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic against a transaction-level model.
// The driver queues expected deliveries; a separate monitor checks every decode handshake.
module tb_instruction_fetch_unit;
   localparam int MAX_WAIT = 16;
   localparam int NEVER    = 1000;
   localparam int K_NORM = 0, K_MIS = 1, K_RREQ = 2, K_RHOLD = 3;
   localparam int C_ISSUE = 0, C_VALID = 1, C_BUS_IDLE = 2;
   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
      logic        fault;
   } exp_t;
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   instruction_fetch_unit_if bus ();
   instruction_fetch_unit #(.DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT), .NOP_INSTR(32'h0)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus)
   );
   always #5 CLK = ~CLK;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        sb_q[$];
   int          r_lat = NEVER;
   logic        r_err = 1'b0;
   logic [31:0] r_data = '0;
   logic [31:0] cur_addr = '0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask
   function automatic bit cond(input int sel);
      case (sel)
         C_ISSUE: return bus.mem_req || bus.instr_valid;
         C_VALID: return bus.instr_valid;
         default: return !bus.mem_req;
      endcase
   endfunction
   task automatic wait_cond(input int sel, input int limit, input string nm);
      int n;
      n = 0;
      while (!cond(sel) && n < limit) begin
         @(negedge CLK);
         n++;
      end
      vectors++;
      if (!cond(sel)) begin
         miscompares++;
         $display("FAIL %s: got no event in %0d cycles, want event within bound", nm, limit);
      end
   endtask
   // memory: acks after r_lat request cycles (never if r_lat >= MAX_WAIT), garbage otherwise
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_err = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RESET || !bus.mem_req) begin
            if (RESET && cnt > 0 && r_lat >= MAX_WAIT) chk("timeout_len", cnt, MAX_WAIT);
            cnt = 0;
            bus.mem_ack = 1'b0;
         end else begin
            chk("mem_addr", bus.mem_addr, cur_addr);
            bus.mem_ack = cnt == r_lat;
            bus.mem_rdata = cnt == r_lat ? r_data : $urandom;
            bus.mem_err = cnt == r_lat ? r_err : 1'($urandom);
            cnt++;
         end
      end
   end
   // monitor: handshakes, held outputs, pc_advance timing and the re-issue gap
   initial begin
      bit exp_adv, prev_adv, prev_hold;
      logic [31:0] p_out, p_pc;
      logic p_f;
      exp_t e;
      exp_adv = 0; prev_adv = 0; prev_hold = 0;
      p_out = '0; p_pc = '0; p_f = 1'b0;
      forever begin
         @(negedge CLK);
         #2;
         if (!RESET) begin
            exp_adv = 0; prev_adv = 0; prev_hold = 0;
         end else begin
            chk("pc_advance", 32'(bus.pc_advance), 32'(exp_adv));
            if (prev_adv) chk("reissue_gap_req", 32'(bus.mem_req), 0);
            if (prev_hold) begin
               chk("hold_valid", 32'(bus.instr_valid), 1);
               chk("hold_out", bus.instr_out, p_out);
               chk("hold_pc", bus.instr_pc, p_pc);
               chk("hold_fault", 32'(bus.fetch_fault), 32'(p_f));
            end
            prev_adv = bus.pc_advance;
            exp_adv = 0;
            if (bus.instr_valid && bus.decode_ready && !bus.redirect) begin
               if (sb_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_delivery: got %h @%h, want none", bus.instr_out, bus.instr_pc);
               end else begin
                  e = sb_q.pop_front();
                  chk("instr_out", bus.instr_out, e.word);
                  chk("instr_pc", bus.instr_pc, e.pc);
                  chk("fetch_fault", 32'(bus.fetch_fault), 32'(e.fault));
                  exp_adv = !e.fault;
               end
            end
            prev_hold = bus.instr_valid && !bus.decode_ready && !bus.redirect;
            p_out = bus.instr_out; p_pc = bus.instr_pc; p_f = bus.fetch_fault;
         end
      end
   end
   task automatic run_fetch(input int kind, input logic [31:0] addr, input int lat, input bit err,
                            input logic [31:0] data, input int rdelay);
      bit fault;
      fault = addr[1:0] != 2'b00 || err || lat >= MAX_WAIT;
      r_lat = lat; r_err = err; r_data = data; cur_addr = addr;
      if (kind == K_NORM || kind == K_MIS) sb_q.push_back({fault ? 32'h0 : data, addr, fault});
      bus.pc_in = addr;
      bus.pc_valid = 1'b1;
      wait_cond(C_ISSUE, 6, "issue");
      bus.pc_valid = 1'b0;
      if (addr[1:0] != 2'b00) chk("misaligned_no_req", 32'(bus.mem_req), 0);
      if (kind == K_RREQ) begin
         bus.redirect = 1'b1;
         @(negedge CLK);
         bus.redirect = 1'b0;
         wait_cond(C_BUS_IDLE, MAX_WAIT + 4, "drop_release");
         repeat (3) begin
            @(negedge CLK);
            chk("dropped_valid", 32'(bus.instr_valid), 0);
         end
         return;
      end
      wait_cond(C_VALID, MAX_WAIT + 4, "deliver");
      repeat (rdelay) @(negedge CLK);
      if (kind == K_RHOLD) begin
         bus.decode_ready = 1'($urandom);
         bus.redirect = 1'b1;
         @(negedge CLK);
         bus.redirect = 1'b0;
         bus.decode_ready = 1'b0;
         chk("redirect_hold_valid", 32'(bus.instr_valid), 0);
         return;
      end
      bus.decode_ready = 1'b1;
      @(negedge CLK);
      bus.decode_ready = 1'b0;
      if (fault) begin
         bus.pc_in = $urandom & ~32'h3;
         bus.pc_valid = 1'b1;
         repeat (4) begin
            @(negedge CLK);
            chk("halt_req", 32'(bus.mem_req), 0);
            chk("halt_valid", 32'(bus.instr_valid), 0);
            chk("halt_fault", 32'(bus.fetch_fault), 1);
         end
         bus.pc_valid = 1'b0;
         bus.redirect = 1'b1;
         @(negedge CLK);
         bus.redirect = 1'b0;
         chk("halt_exit_fault", 32'(bus.fetch_fault), 0);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_mem_req"}, 32'(bus.mem_req), 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 0);
      chk({tag, "_instr_out"}, bus.instr_out, 0);
      chk({tag, "_instr_pc"}, bus.instr_pc, 0);
      chk({tag, "_fetch_fault"}, 32'(bus.fetch_fault), 0);
      chk({tag, "_pc_advance"}, 32'(bus.pc_advance), 0);
   endtask
   initial begin
      int k, kind, lat;
      logic [31:0] a;
      bus.pc_in = '0; bus.pc_valid = 1'b0; bus.redirect = 1'b0; bus.decode_ready = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset("por");
      RESET = 1'b1;
      @(negedge CLK);
      run_fetch(K_NORM, 32'h100, 2, 0, 32'h8C220004, 0);
      run_fetch(K_NORM, 32'h104, 1, 0, 32'h12345678, 5);
      run_fetch(K_RREQ, 32'h180, 3, 0, 32'hDEADBEEF, 0);
      run_fetch(K_NORM, 32'h200, 0, 0, 32'hCAFEF00D, 1);
      run_fetch(K_MIS, 32'h102, 0, 0, 32'h0, 2);
      run_fetch(K_NORM, 32'h300, NEVER, 0, 32'h0, 0);
      run_fetch(K_NORM, 32'h304, 1, 1, 32'hFFFFFFFF, 0);
      run_fetch(K_NORM, 32'h308, MAX_WAIT - 1, 0, 32'hA5A5A5A5, 0);
      run_fetch(K_NORM, 32'h30C, MAX_WAIT, 0, 32'h5A5A5A5A, 0);
      run_fetch(K_RHOLD, 32'h310, 2, 0, 32'h11112222, 3);
      run_fetch(K_RREQ, 32'h314, NEVER, 0, 32'h0, 0);
      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 19);
         kind = k < 12 ? K_NORM : k < 14 ? K_MIS : k < 17 ? K_RREQ : K_RHOLD;
         a = $urandom & ~32'h3;
         if (kind == K_MIS) a[1:0] = 2'($urandom_range(1, 3));
         lat = $urandom_range(0, 9) == 0 ? $urandom_range(14, 20) : $urandom_range(0, 5);
         if (kind == K_RREQ && lat == 0) lat = 1;
         run_fetch(kind, a, lat, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 4));
      end
      r_lat = NEVER; cur_addr = 32'h400;
      bus.pc_in = 32'h400;
      bus.pc_valid = 1'b1;
      wait_cond(C_ISSUE, 6, "rst_req_issue");
      bus.pc_valid = 1'b0;
      repeat (2) @(negedge CLK);
      #3 RESET = 1'b0;
      #1 chk_reset("rst_req");
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      run_fetch(K_NORM, 32'h404, 2, 0, 32'h0BADCAFE, 0);
      bus.pc_in = 32'h501;
      bus.pc_valid = 1'b1;
      wait_cond(C_VALID, 6, "rst_hold_valid");
      bus.pc_valid = 1'b0;
      @(negedge CLK);
      #3 RESET = 1'b0;
      #1 chk_reset("rst_hold");
      sb_q.delete();
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      run_fetch(K_NORM, 32'h500, 2, 0, 32'h600DF00D, 1);
      repeat (4) @(negedge CLK);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
